ws2812_rx: RTL and testbench

- Single-wire WS2812 receiver/decoder that models one pixel node on the LED chain.
- Recovers bits from the high-pulse width on `din` and assembles 24-bit words.
- Reports frame boundaries when it detects a reset gap (line held low).
- Once its own words are consumed, forwards the remaining bitstream on `dout`, as a real pixel does.
- Uses: loopback verification of the team's WS2812 transmitter on TangNano 20k, and as a daisy-chain emulator.

---
 rtl/ws2812_pkg.sv | 30 +++
 rtl/ws2812_edge_sync.sv | 42 ++++
 rtl/ws2812_rx.sv | 199 +++++++++++++++++++
 tb/tb_ws2812_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared WS2812 state encodings and timing constants
// Shared by the transmitter and ws2812_rx so both sides derive pulse
// timing from the same clock frequency.
//   state_t        receiver FSM encodings
//   ns_to_cycles   nanoseconds -> clock cycles, rounded up
//   *_NS           nominal WS2812 timings; THRESH_NS is the midpoint of T0H/T1H
package ws2812_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  localparam int unsigned CNT_W       = 16;
  localparam int unsigned DEF_CLK_FRE = 27_000_000;
  localparam int unsigned T0H_NS      = 400;
  localparam int unsigned T1H_NS      = 850;
  localparam int unsigned THRESH_NS   = (T0H_NS + T1H_NS) / 2;
  localparam int unsigned MAX_HIGH_NS = 2_000;
  localparam int unsigned RESET_NS    = 50_000;

  function automatic int unsigned ns_to_cycles(input int unsigned clk_fre,
                                               input int unsigned ns);
    logic [63:0] cyc;
    cyc = (64'(clk_fre) * 64'(ns) + 64'd999_999_999) / 64'd1_000_000_000;
    return cyc[31:0];
  endfunction

endpackage

// File: rtl/ws2812_edge_sync.sv
// rtl/ws2812_edge_sync.sv - 2-FF synchronizer plus edge detect for the WS2812 line
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   din         asynchronous serial line
//   din_sync    synchronized level (second flop)
//   rise, fall  single-cycle edge pulses of din_sync against the delay flop
module ws2812_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic din_sync,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign din_sync = s2_q;
  assign rise     = s2_q & ~s3_q;
  assign fall     = ~s2_q & s3_q;

endmodule

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 receiver/decoder modelling one pixel node
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   din          raw WS2812 serial line
//   data_out     last completed word, bit 0 = first bit received
//   data_valid   one-cycle pulse when data_out updates
//   word_idx     index of data_out within its frame, saturates at 255
//   frame_done   pulse when a reset gap closes a frame that carried bits
//   err          pulse on an over-long high or a partial word at frame end
//   dout         forwarded line once PIXEL_SKIP words have been consumed
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned CLK_FRE      = DEF_CLK_FRE,
  parameter int unsigned BIT_THRESH   = ns_to_cycles(CLK_FRE, THRESH_NS),
  parameter int unsigned MAX_HIGH     = ns_to_cycles(CLK_FRE, MAX_HIGH_NS),
  parameter int unsigned RESET_CYCLES = ns_to_cycles(CLK_FRE, RESET_NS),
  parameter int unsigned WORD_WIDTH   = 24,
  parameter int unsigned PIXEL_SKIP   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  din,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [7:0]            word_idx,
  output logic                  frame_done,
  output logic                  err,
  output logic                  dout
);

  localparam int unsigned BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W:0]   THRESH_L   = (CNT_W + 1)'(BIT_THRESH);
  localparam logic [CNT_W:0]   MAX_HIGH_L = (CNT_W + 1)'(MAX_HIGH);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_WIDTH - 1);
  localparam logic [8:0]       SKIP_L     = 9'(PIXEL_SKIP);
  // Forwarding state a fresh frame starts with: on from the start when no
  // words are to be consumed.
  localparam logic             FWD_RELOAD = (PIXEL_SKIP == 0);

  logic din_sync, rise, fall;

  ws2812_edge_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_sync (din_sync),
    .rise     (rise),
    .fall     (fall)
  );

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]            word_cnt_q, word_cnt_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic                  word_pend_q, word_pend_d;
  logic                  fwd_en_q, fwd_en_d;
  logic                  frame_seen_q, frame_seen_d;
  logic [WORD_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic [7:0]            word_idx_q, word_idx_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_q, err_d;
  logic                  dout_q, dout_d;

  // cnt is cleared on the edge cycle itself, so the level has already been
  // present for cnt+1 cycles when cnt is sampled.
  logic [CNT_W:0]   level_len;
  logic [CNT_W-1:0] cnt_inc;
  assign level_len = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = (rise | fall) ? '0 : cnt_inc;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    shreg_d      = shreg_q;
    word_pend_d  = 1'b0;
    fwd_en_d     = fwd_en_q;
    frame_seen_d = frame_seen_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    word_idx_d   = word_idx_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    dout_d       = fwd_en_q & din_sync;

    // Publish the word one cycle after its last falling edge. Forwarding is
    // enabled while the line is low, so the first forwarded bit is whole.
    if (word_pend_q) begin
      data_out_d   = shreg_q;
      word_idx_d   = word_cnt_q;
      data_valid_d = 1'b1;
      word_cnt_d   = (word_cnt_q == 8'hFF) ? 8'hFF : word_cnt_q + 8'd1;
      if (({1'b0, word_cnt_q} + 9'd1) == SKIP_L) begin
        fwd_en_d = 1'b1;
      end
    end

    unique case (state_q)
      S_SYNC: begin
        if (din_sync) begin
          cnt_d = '0;
        end else if (cnt_q == RESET_LAST) begin
          state_d      = S_LOW;
          bit_cnt_d    = '0;
          word_cnt_d   = '0;
          fwd_en_d     = FWD_RELOAD;
          frame_seen_d = 1'b0;
        end
      end

      S_LOW: begin
        if (rise) begin
          state_d = S_HIGH;
        end else if (cnt_q == RESET_LAST) begin
          // cnt saturates past this value, so a long gap ends a frame once.
          err_d        = (bit_cnt_q != '0);
          frame_done_d = frame_seen_q;
          bit_cnt_d    = '0;
          word_cnt_d   = '0;
          fwd_en_d     = FWD_RELOAD;
          frame_seen_d = 1'b0;
        end
      end

      S_HIGH: begin
        if (fall) begin
          shreg_d[bit_cnt_q] = (level_len >= THRESH_L);
          frame_seen_d       = 1'b1;
          state_d            = S_LOW;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d   = '0;
            word_pend_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else if (level_len >= MAX_HIGH_L) begin
          err_d        = 1'b1;
          state_d      = S_SYNC;
          cnt_d        = '0;
          bit_cnt_d    = '0;
          fwd_en_d     = 1'b0;
          frame_seen_d = 1'b0;
        end
      end

      default: begin
        state_d = S_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_SYNC;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      shreg_q      <= '0;
      word_pend_q  <= 1'b0;
      fwd_en_q     <= 1'b0;
      frame_seen_q <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      word_idx_q   <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      dout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      shreg_q      <= shreg_d;
      word_pend_q  <= word_pend_d;
      fwd_en_q     <= fwd_en_d;
      frame_seen_q <= frame_seen_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      word_idx_q   <= word_idx_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      dout_q       <= dout_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign word_idx   = word_idx_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign dout       = dout_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - directed self-checking bench for ws2812_rx
module tb_ws2812_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic [23:0] data_out;
  logic        data_valid;
  logic [7:0]  word_idx;
  logic        frame_done;
  logic        err;
  logic        dout;

  ws2812_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .data_out   (data_out),
    .data_valid (data_valid),
    .word_idx   (word_idx),
    .frame_done (frame_done),
    .err        (err),
    .dout       (dout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  int cyc = 0;
  int t_start = 0;
  int fd_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int dout_mode = 0;
  int dout_bad = 0;
  int dout_high = 0;
  logic h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
  logic [23:0] dv_data[$];
  logic [7:0]  dv_idx[$];

  // Observation at the falling edge; h3 is din as it stood 3 cycles back.
  always @(negedge clk) begin
    cyc++;
    if (data_valid === 1'b1) begin
      dv_data.push_back(data_out);
      dv_idx.push_back(word_idx);
    end
    if (frame_done === 1'b1) fd_cnt++;
    if (err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (dout_mode == 1 && dout !== 1'b0) dout_bad++;
    if (dout_mode == 2) begin
      if (dout !== h3) dout_bad++;
      if (dout === 1'b1) dout_high++;
    end
    h3 = h2;
    h2 = h1;
    h1 = din;
  end

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      din = v;
      if (i == 0) t_start = cyc;
    end
  endtask

  task automatic send_pulse(input int hi, input int lo);
    drive(1'b1, hi);
    drive(1'b0, lo);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_pulse(23, 11);
    else   send_pulse(11, 23);
  endtask

  task automatic send_bits(input logic [23:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [23:0] w);
    send_bits(w, 0, 23);
  endtask

  task automatic clear_mon();
    dv_data.delete();
    dv_idx.delete();
    fd_cnt = 0;
    err_cnt = 0;
    dout_bad = 0;
    dout_high = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (data_out !== 24'h0) $display("FAIL reset_data_out got %h exp 000000", data_out); else n_pass++;
    n_checks++; if (data_valid !== 1'b0) $display("FAIL reset_data_valid got %b exp 0", data_valid); else n_pass++;
    n_checks++; if (word_idx !== 8'h0) $display("FAIL reset_word_idx got %h exp 00", word_idx); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", frame_done); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
    n_checks++; if (dout !== 1'b0) $display("FAIL reset_dout got %b exp 0", dout); else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    clear_mon();
    drive(1'b0, 1400);
    send_word(24'h000001);
    drive(1'b0, 1400);
    n_checks++; if (dv_data.size() != 1) $display("FAIL single_dv_count got %0d exp 1", dv_data.size()); else n_pass++;
    n_checks++; if (dv_data[0] !== 24'h000001) $display("FAIL single_data got %h exp 000001", dv_data[0]); else n_pass++;
    n_checks++; if (dv_idx[0] !== 8'd0) $display("FAIL single_idx got %0d exp 0", dv_idx[0]); else n_pass++;
    n_checks++; if (fd_cnt != 1) $display("FAIL single_frame_done got %0d exp 1", fd_cnt); else n_pass++;
    n_checks++; if (err_cnt != 0) $display("FAIL single_err got %0d exp 0", err_cnt); else n_pass++;
  endtask

  task automatic test_threshold();
    logic [23:0] w;
    clear_mon();
    send_pulse(16, 20);
    send_pulse(17, 20);
    send_bits(24'h000000, 2, 23);
    drive(1'b0, 1400);
    w = dv_data[0];
    n_checks++; if (dv_data.size() != 1) $display("FAIL thresh_dv_count got %0d exp 1", dv_data.size()); else n_pass++;
    n_checks++; if (w[0] !== 1'b0) $display("FAIL thresh_16_cycles got %b exp 0", w[0]); else n_pass++;
    n_checks++; if (w[1] !== 1'b1) $display("FAIL thresh_17_cycles got %b exp 1", w[1]); else n_pass++;
    n_checks++; if (w !== 24'h000002) $display("FAIL thresh_word got %h exp 000002", w); else n_pass++;
    n_checks++; if (dv_idx[0] !== 8'd0) $display("FAIL thresh_idx got %0d exp 0", dv_idx[0]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int exp_high;
    clear_mon();
    exp_high = $countones(24'h123456) * 23 + (24 - $countones(24'h123456)) * 11;
    dout_mode = 1;
    send_word(24'hA5C30F);
    n_checks++; if (dout_bad != 0) $display("FAIL b2b_dout_quiet_word0 got %0d bad cycles exp 0", dout_bad); else n_pass++;
    dout_bad = 0;
    dout_mode = 2;
    send_word(24'h123456);
    drive(1'b0, 1400);
    dout_mode = 0;
    n_checks++; if (dv_data.size() != 2) $display("FAIL b2b_dv_count got %0d exp 2", dv_data.size()); else n_pass++;
    n_checks++; if (dv_data[0] !== 24'hA5C30F) $display("FAIL b2b_data0 got %h exp a5c30f", dv_data[0]); else n_pass++;
    n_checks++; if (dv_idx[0] !== 8'd0) $display("FAIL b2b_idx0 got %0d exp 0", dv_idx[0]); else n_pass++;
    n_checks++; if (dv_data[1] !== 24'h123456) $display("FAIL b2b_data1 got %h exp 123456", dv_data[1]); else n_pass++;
    n_checks++; if (dv_idx[1] !== 8'd1) $display("FAIL b2b_idx1 got %0d exp 1", dv_idx[1]); else n_pass++;
    n_checks++; if (dout_bad != 0) $display("FAIL b2b_dout_lag got %0d bad cycles exp 0", dout_bad); else n_pass++;
    n_checks++; if (dout_high != exp_high) $display("FAIL b2b_dout_high got %0d exp %0d", dout_high, exp_high); else n_pass++;
    n_checks++; if (dout !== 1'b0) $display("FAIL b2b_dout_after_gap got %b exp 0", dout); else n_pass++;
    n_checks++; if (fd_cnt != 1) $display("FAIL b2b_frame_done got %0d exp 1", fd_cnt); else n_pass++;
  endtask

  task automatic test_overlong();
    int t0;
    clear_mon();
    send_bits(24'h00001F, 0, 4);
    drive(1'b1, 60);
    t0 = t_start;
    drive(1'b0, 20);
    send_bits(24'hFFFFFF, 0, 9);
    drive(1'b0, 1400);
    n_checks++; if (err_cnt != 1) $display("FAIL overlong_err_count got %0d exp 1", err_cnt); else n_pass++;
    // 3 cycles of detection latency after the 54th high cycle, plus the
    // one-cycle offset between drive time and the first observation edge.
    n_checks++; if (err_cyc - t0 != 58) $display("FAIL overlong_err_time got %0d exp 58", err_cyc - t0); else n_pass++;
    n_checks++; if (dv_data.size() != 0) $display("FAIL overlong_no_dv got %0d exp 0", dv_data.size()); else n_pass++;
    send_word(24'h5A5A5A);
    drive(1'b0, 1400);
    n_checks++; if (dv_data.size() != 1) $display("FAIL overlong_recover_count got %0d exp 1", dv_data.size()); else n_pass++;
    n_checks++; if (dv_data[0] !== 24'h5A5A5A) $display("FAIL overlong_recover_data got %h exp 5a5a5a", dv_data[0]); else n_pass++;
    n_checks++; if (dv_idx[0] !== 8'd0) $display("FAIL overlong_recover_idx got %0d exp 0", dv_idx[0]); else n_pass++;
    n_checks++; if (fd_cnt != 1) $display("FAIL overlong_frame_done got %0d exp 1", fd_cnt); else n_pass++;
  endtask

  task automatic test_partial();
    clear_mon();
    send_bits(24'h0002AA, 0, 9);
    drive(1'b0, 1400);
    n_checks++; if (err_cnt != 1) $display("FAIL partial_err got %0d exp 1", err_cnt); else n_pass++;
    n_checks++; if (fd_cnt != 1) $display("FAIL partial_frame_done got %0d exp 1", fd_cnt); else n_pass++;
    n_checks++; if (dv_data.size() != 0) $display("FAIL partial_no_dv got %0d exp 0", dv_data.size()); else n_pass++;
    clear_mon();
    send_word(24'h0F0F0F);
    drive(1'b0, 1400);
    n_checks++; if (dv_data.size() != 1) $display("FAIL partial_next_count got %0d exp 1", dv_data.size()); else n_pass++;
    n_checks++; if (dv_data[0] !== 24'h0F0F0F) $display("FAIL partial_next_data got %h exp 0f0f0f", dv_data[0]); else n_pass++;
    n_checks++; if (dv_idx[0] !== 8'd0) $display("FAIL partial_next_idx got %0d exp 0", dv_idx[0]); else n_pass++;
    n_checks++; if (err_cnt != 0) $display("FAIL partial_next_err got %0d exp 0", err_cnt); else n_pass++;
  endtask

  task automatic test_midreset();
    logic [23:0] w;
    w = 24'hABCDEF;
    clear_mon();
    send_bits(w, 0, 11);
    @(posedge clk);
    #1;
    din = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (data_out !== 24'h0) $display("FAIL midrst_data_out got %h exp 000000", data_out); else n_pass++;
    n_checks++; if (word_idx !== 8'h0) $display("FAIL midrst_word_idx got %h exp 00", word_idx); else n_pass++;
    n_checks++; if ({data_valid, frame_done, err, dout} !== 4'b0000) $display("FAIL midrst_pulses got %b exp 0000", {data_valid, frame_done, err, dout}); else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 6);
    drive(1'b0, 23);
    send_bits(w, 13, 23);
    drive(1'b0, 1400);
    n_checks++; if (dv_data.size() != 0) $display("FAIL midrst_ignored_dv got %0d exp 0", dv_data.size()); else n_pass++;
    n_checks++; if (fd_cnt != 0) $display("FAIL midrst_ignored_fd got %0d exp 0", fd_cnt); else n_pass++;
    n_checks++; if (err_cnt != 0) $display("FAIL midrst_ignored_err got %0d exp 0", err_cnt); else n_pass++;
    send_word(24'h00FF00);
    drive(1'b0, 1400);
    n_checks++; if (dv_data.size() != 1) $display("FAIL midrst_resume_count got %0d exp 1", dv_data.size()); else n_pass++;
    n_checks++; if (dv_data[0] !== 24'h00FF00) $display("FAIL midrst_resume_data got %h exp 00ff00", dv_data[0]); else n_pass++;
    n_checks++; if (dv_idx[0] !== 8'd0) $display("FAIL midrst_resume_idx got %0d exp 0", dv_idx[0]); else n_pass++;
    n_checks++; if (fd_cnt != 1) $display("FAIL midrst_resume_fd got %0d exp 1", fd_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_threshold();
    test_back_to_back();
    test_overlong();
    test_partial();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
